// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 sliding-window front end of the conv kernel.
package conv_pkg;

  localparam int CONV_DATA_W = 8;
  localparam int CONV_IMG_W  = 28;
  localparam int CONV_IMG_H  = 28;

  localparam int WIN_K     = 3;
  localparam int WIN_LANES = WIN_K * WIN_K;

  // Window row order: oldest row on top. Column order: leftmost first.
  localparam int ROW_OLD   = 0;
  localparam int ROW_MID   = 1;
  localparam int ROW_NEW   = 2;
  localparam int COL_LEFT  = 0;
  localparam int COL_MID   = 1;
  localparam int COL_RIGHT = 2;

  typedef logic [CONV_DATA_W-1:0] pixel_t;
  typedef pixel_t [WIN_LANES-1:0] window_t;

  // Control phase, decoded from the raster counters.
  typedef enum logic [1:0] {
    PH_FILL  = 2'd0,
    PH_PRIME = 2'd1,
    PH_EMIT  = 2'd2
  } phase_t;

  // Flattened lane index of window element (r, c).
  function automatic int lane_idx(input int r, input int c);
    return r * WIN_K + c;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of pixel storage: combinational read and clocked write at the
// same address, so a read in the write cycle returns the previous row's pixel.
module conv_line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 28,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Old contents are visible until the write edge.
  assign rd_data = mem[addr];

  // Row storage is never reset; every entry is rewritten before it is used.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator (valid padding, stride 1) feeding ifmap_3x3.
//
// phase    | meaning
// ---------+--------------------------------------------------------------
// PH_FILL  | row < 2: line buffers still filling, nothing emitted
// PH_PRIME | row >= 2, col < 2: left window columns are stale, no emit
// PH_EMIT  | row >= 2, col >= 2: each accepted pixel completes a window
//
// The phase is decoded from the row/col counters; there is no phase register.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_W = CONV_DATA_W,
  parameter int IMG_W  = CONV_IMG_W,
  parameter int IMG_H  = CONV_IMG_H
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clear,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_W-1:0]                  in_pixel,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIN_LANES-1:0][DATA_W-1:0]   out_window,
  output logic [$clog2(IMG_H)-1:0]           out_row,
  output logic [$clog2(IMG_W)-1:0]           out_col,
  output logic                               frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;

  logic          accept;
  logic          emit;
  logic          last_pix;
  phase_t        phase;

  logic [DATA_W-1:0] lb0_rd;
  logic [DATA_W-1:0] lb1_rd;

  // Two most recent window columns (left, middle) and the column arriving now.
  logic [WIN_K-1:0][DATA_W-1:0] col_a;
  logic [WIN_K-1:0][DATA_W-1:0] col_b;
  logic [WIN_K-1:0][DATA_W-1:0] new_col;
  logic [WIN_LANES-1:0][DATA_W-1:0] next_window;

  // Ready only when the output slot is free or being drained; never in reset or clear.
  assign in_ready = rst_n & ~clear & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // lb1 holds row-2, lb0 holds row-1 at the current column.
  conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(CW)) u_lb0 (
    .clk     (clk),
    .addr    (col_cnt),
    .wr_en   (accept),
    .wr_data (in_pixel),
    .rd_data (lb0_rd)
  );

  conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk     (clk),
    .addr    (col_cnt),
    .wr_en   (accept),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  // Decode the control phase and the end-of-frame position from the counters.
  always_comb begin
    phase = PH_FILL;
    if (row_cnt >= ROW_TWO) begin
      phase = (col_cnt >= COL_TWO) ? PH_EMIT : PH_PRIME;
    end
    last_pix = (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
    emit     = accept && (phase == PH_EMIT);
  end

  // Assemble the incoming column, oldest row on top.
  always_comb begin
    new_col          = '0;
    new_col[ROW_OLD] = lb1_rd;
    new_col[ROW_MID] = lb0_rd;
    new_col[ROW_NEW] = in_pixel;
  end

  for (genvar r = 0; r < WIN_K; r++) begin : g_lane
    assign next_window[lane_idx(r, COL_LEFT)]  = col_a[r];
    assign next_window[lane_idx(r, COL_MID)]   = col_b[r];
    assign next_window[lane_idx(r, COL_RIGHT)] = new_col[r];
  end

  // Column shift register; stale columns after a row wrap are never emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      col_a <= col_b;
      col_b <= new_col;
    end
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (clear) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (accept) begin
      if (col_cnt == COL_LAST) begin
        col_cnt <= '0;
        row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + RW'(1);
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end
    end
  end

  // Output slot: load on emit, hold until consumed, pulse frame_done on the last window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_window <= '0;
      out_row    <= '0;
      out_col    <= '0;
    end else if (clear) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= emit && last_pix;
      if (emit) begin
        out_valid  <= 1'b1;
        out_window <= next_window;
        out_row    <= row_cnt - ROW_TWO;
        out_col    <= col_cnt - COL_TWO;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule
